// File: rtl/weight_csr_encoder.sv
// -----------------------------------------------------------------------------
// weight_csr_encoder
//
// Scans a dense filter-weight memory (layout s outer, r middle, k inner) and
// emits only the nonzero weights as (r, k, w, idx) entries. While it does so it
// builds the per-column pointer array and the total entry count used by the
// sparse RF stage downstream. One scan runs per accepted i_start and ends with
// a single-cycle o_finish pulse.
//
// Optional build macro: WCSR_THRESH_EN
//   defined   : a weight counts as nonzero only if |i_rdata| > i_thresh
//   undefined : a weight counts as nonzero if i_rdata != 0 (i_thresh ignored)
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start            start pulse, sampled only in IDLE
//   i_r_num/s_num/k_num geometry (rows, columns, channels), latched on start
//   i_thresh           prune threshold (WCSR_THRESH_EN only)
//   o_raddr / i_rdata  weight memory port, 1-cycle read latency
//   o_valid, o_r, o_k, o_w, o_idx  emitted entry
//   o_ptr              column pointers, S_MAX+1 slots of 11 bits
//   o_length           total entries emitted
//   o_busy             high outside IDLE
//   o_finish           one-cycle done pulse
//   o_overflow         sticky, a nonzero arrived with the list already full
// -----------------------------------------------------------------------------
module weight_csr_encoder #(
    parameter int R_MAX   = 5,
    parameter int S_MAX   = 4,
    parameter int K_MAX   = 32,
    parameter int WW      = 8,
    parameter int NNZ_MAX = 2047
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [2:0]            i_r_num,
    input  logic [2:0]            i_s_num,
    input  logic [5:0]            i_k_num,
    input  logic [WW-2:0]         i_thresh,
    output logic [10:0]           o_raddr,
    input  logic [WW-1:0]         i_rdata,
    output logic                  o_valid,
    output logic [2:0]            o_r,
    output logic [4:0]            o_k,
    output logic [WW-1:0]         o_w,
    output logic [10:0]           o_idx,
    output logic [S_MAX:0][10:0]  o_ptr,
    output logic [10:0]           o_length,
    output logic                  o_busy,
    output logic                  o_finish,
    output logic                  o_overflow
);

    localparam logic [2:0]  R_LIM   = 3'(R_MAX);
    localparam logic [2:0]  S_LIM   = 3'(S_MAX);
    localparam logic [5:0]  K_LIM   = 6'(K_MAX);
    localparam logic [10:0] NNZ_CAP = 11'(NNZ_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          r_num_q, r_num_d, s_num_q, s_num_d;
    logic [5:0]          k_num_q, k_num_d;
    logic [2:0]          s_q, s_d, r_q, r_d;       // tag of the address being issued
    logic [4:0]          k_q, k_d;
    logic [10:0]         addr_q, addr_d;
    logic                v1_q, v1_d;               // tag stage aligned with i_rdata
    logic [2:0]          s1_q, s1_d, r1_q, r1_d;
    logic [4:0]          k1_q, k1_d;
    logic                drain_q, drain_d;
    logic [10:0]         count_q, count_d;
    logic                valid_q, valid_d;
    logic [2:0]          r_out_q, r_out_d;
    logic [4:0]          k_out_q, k_out_d;
    logic [WW-1:0]       w_q, w_d;
    logic [10:0]         idx_q, idx_d;
    logic [S_MAX:0][10:0] ptr_q, ptr_d;
    logic [10:0]         length_q, length_d;
    logic                finish_q, finish_d;
    logic                overflow_q, overflow_d;

    // Geometry is clamped to the supported maxima so tags never index past
    // the pointer array.
    logic [2:0] r_clamp, s_clamp;
    logic [5:0] k_clamp;
    assign r_clamp = (i_r_num > R_LIM) ? R_LIM : i_r_num;
    assign s_clamp = (i_s_num > S_LIM) ? S_LIM : i_s_num;
    assign k_clamp = (i_k_num > K_LIM) ? K_LIM : i_k_num;

    logic last_tag;
    assign last_tag = (s_q == s_num_q - 3'd1) && (r_q == r_num_q - 3'd1) &&
                      ({1'b0, k_q} == k_num_q - 6'd1);

    logic is_nz;
`ifdef WCSR_THRESH_EN
    // Magnitude at WW+1 bits so the most negative weight does not wrap.
    logic [WW:0] rdata_ext, rdata_mag;
    assign rdata_ext = {i_rdata[WW-1], i_rdata};
    assign rdata_mag = rdata_ext[WW] ? (~rdata_ext + 1'b1) : rdata_ext;
    assign is_nz     = rdata_mag > {2'b00, i_thresh};
`else
    // Threshold has no function in this build.
    logic unused_thresh;
    assign unused_thresh = ^i_thresh;
    assign is_nz         = (i_rdata != '0);
`endif

    always_comb begin
        state_d    = state_q;
        r_num_d    = r_num_q;
        s_num_d    = s_num_q;
        k_num_d    = k_num_q;
        s_d        = s_q;
        r_d        = r_q;
        k_d        = k_q;
        addr_d     = addr_q;
        v1_d       = 1'b0;
        s1_d       = s1_q;
        r1_d       = r1_q;
        k1_d       = k1_q;
        drain_d    = drain_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        r_out_d    = r_out_q;
        k_out_d    = k_out_q;
        w_d        = w_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        length_d   = length_q;
        finish_d   = 1'b0;
        overflow_d = overflow_q;

        // Output stage: the tag delayed one cycle meets the read data here.
        if (v1_q) begin
            // First tag of a column snapshots the running count before this
            // column's own entry is added.
            if (r1_q == 3'd0 && k1_q == 5'd0) begin
                for (int j = 0; j <= S_MAX; j++) begin
                    if (s1_q == 3'(j)) ptr_d[j] = count_q;
                end
            end
            if (is_nz) begin
                if (count_q < NNZ_CAP) begin
                    valid_d = 1'b1;
                    r_out_d = r1_q;
                    k_out_d = k1_q;
                    w_d     = i_rdata;
                    idx_d   = count_q;
                    count_d = count_q + 11'd1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    r_num_d    = r_clamp;
                    s_num_d    = s_clamp;
                    k_num_d    = k_clamp;
                    s_d        = 3'd0;
                    r_d        = 3'd0;
                    k_d        = 5'd0;
                    addr_d     = 11'd0;
                    count_d    = 11'd0;
                    ptr_d      = '0;
                    overflow_d = 1'b0;
                    if (r_clamp == 3'd0 || s_clamp == 3'd0 || k_clamp == 6'd0) begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                        length_d = 11'd0;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                v1_d = 1'b1;
                s1_d = s_q;
                r1_d = r_q;
                k1_d = k_q;
                if (last_tag) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    addr_d = addr_q + 11'd1;
                    if ({1'b0, k_q} == k_num_q - 6'd1) begin
                        k_d = 5'd0;
                        if (r_q == r_num_q - 3'd1) begin
                            r_d = 3'd0;
                            s_d = s_q + 3'd1;
                        end else begin
                            r_d = r_q + 3'd1;
                        end
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    // Pipeline is empty: unused columns point past the end.
                    state_d  = ST_DONE;
                    finish_d = 1'b1;
                    length_d = count_q;
                    for (int j = 0; j <= S_MAX; j++) begin
                        if (3'(j) >= s_num_q) ptr_d[j] = count_q;
                    end
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            r_num_q    <= '0;
            s_num_q    <= '0;
            k_num_q    <= '0;
            s_q        <= '0;
            r_q        <= '0;
            k_q        <= '0;
            addr_q     <= '0;
            v1_q       <= 1'b0;
            s1_q       <= '0;
            r1_q       <= '0;
            k1_q       <= '0;
            drain_q    <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            r_out_q    <= '0;
            k_out_q    <= '0;
            w_q        <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            length_q   <= '0;
            finish_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_num_q    <= r_num_d;
            s_num_q    <= s_num_d;
            k_num_q    <= k_num_d;
            s_q        <= s_d;
            r_q        <= r_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            v1_q       <= v1_d;
            s1_q       <= s1_d;
            r1_q       <= r1_d;
            k1_q       <= k1_d;
            drain_q    <= drain_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            r_out_q    <= r_out_d;
            k_out_q    <= k_out_d;
            w_q        <= w_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            length_q   <= length_d;
            finish_q   <= finish_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_raddr    = addr_q;
    assign o_valid    = valid_q;
    assign o_r        = r_out_q;
    assign o_k        = k_out_q;
    assign o_w        = w_q;
    assign o_idx      = idx_q;
    assign o_ptr      = ptr_q;
    assign o_length   = length_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_finish   = finish_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_weight_csr_encoder.sv
// -----------------------------------------------------------------------------
// tb_weight_csr_encoder
//
// Two encoders share one weight memory: dut0 with the full list capacity and
// dut1 with the capacity cut to 4 entries. A reference model walks the memory
// in (s, r, k) order with plain loops and produces the expected entry list,
// pointers, length, overflow flag and scan length; a negedge compare process
// checks each cycle of a scan against it.
// -----------------------------------------------------------------------------
module tb_weight_csr_encoder;

    localparam int WW    = 8;
    localparam int S_MAX = 4;

    typedef struct {
        int         r;
        int         k;
        logic [7:0] w;
        int         idx;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start [2];
    logic [2:0]  r_num, s_num;
    logic [5:0]  k_num;
    logic [6:0]  thresh;

    logic [10:0]           raddr  [2];
    logic [7:0]            rdata  [2];
    logic                  valid  [2];
    logic [2:0]            o_r    [2];
    logic [4:0]            o_k    [2];
    logic [7:0]            o_w    [2];
    logic [10:0]           idx    [2];
    logic [S_MAX:0][10:0]  ptr    [2];
    logic [10:0]           length [2];
    logic                  busy   [2];
    logic                  finish [2];
    logic                  ovf    [2];

    logic [7:0] mem [0:1023];

    weight_csr_encoder dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]),
        .i_r_num(r_num), .i_s_num(s_num), .i_k_num(k_num), .i_thresh(thresh),
        .o_raddr(raddr[0]), .i_rdata(rdata[0]),
        .o_valid(valid[0]), .o_r(o_r[0]), .o_k(o_k[0]), .o_w(o_w[0]), .o_idx(idx[0]),
        .o_ptr(ptr[0]), .o_length(length[0]), .o_busy(busy[0]),
        .o_finish(finish[0]), .o_overflow(ovf[0])
    );

    weight_csr_encoder #(.NNZ_MAX(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]),
        .i_r_num(r_num), .i_s_num(s_num), .i_k_num(k_num), .i_thresh(thresh),
        .o_raddr(raddr[1]), .i_rdata(rdata[1]),
        .o_valid(valid[1]), .o_r(o_r[1]), .o_k(o_k[1]), .o_w(o_w[1]), .o_idx(idx[1]),
        .o_ptr(ptr[1]), .o_length(length[1]), .o_busy(busy[1]),
        .o_finish(finish[1]), .o_overflow(ovf[1])
    );

    // Synchronous weight memory, one cycle of read latency.
    always @(posedge clk) begin
        rdata[0] <= mem[raddr[0]];
        rdata[1] <= mem[raddr[1]];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t exp_q[$];
    ent_t got_q[$];
    int   exp_ptr [S_MAX+1];
    int   exp_len, exp_n, fin;
    bit   exp_ovf;

    function automatic bit is_nz(input logic [7:0] w);
`ifdef WCSR_THRESH_EN
        int m;
        m = $signed(w);
        if (m < 0) m = -m;
        return m > int'(thresh);
`else
        return w != 8'd0;
`endif
    endfunction

    task automatic model(input int inst, input int rn, input int sn, input int kn);
        int   cap;
        int   cnt;
        ent_t e;
        cap = (inst == 1) ? 4 : 2047;
        cnt = 0;
        exp_q.delete();
        exp_ovf = 0;
        for (int s = 0; s <= S_MAX; s++) begin
            exp_ptr[s] = cnt;
            if (s < sn) begin
                for (int r = 0; r < rn; r++) begin
                    for (int k = 0; k < kn; k++) begin
                        e.w = mem[(s * rn + r) * kn + k];
                        if (is_nz(e.w)) begin
                            if (cnt < cap) begin
                                e.r = r; e.k = k; e.idx = cnt;
                                exp_q.push_back(e);
                                cnt++;
                            end else begin
                                exp_ovf = 1;
                            end
                        end
                    end
                end
            end
        end
        exp_len = cnt;
        exp_n   = sn * rn * kn;
        fin     = (exp_n == 0) ? 1 : exp_n + 3;
    endtask

    // ---------------- per-cycle compare ----------------
    bit   chk_on   = 0;
    bit   run_done = 0;
    int   cyc      = 0;
    int   ci       = 0;
    ent_t pe;
    ent_t ge;

    always @(negedge clk) begin
        if (chk_on) begin
            cyc++;
            chk("busy", busy[ci], 1);
            if (cyc <= exp_n) chk("raddr", raddr[ci], cyc - 1);
            if (valid[ci]) begin
                ge.r = o_r[ci]; ge.k = o_k[ci]; ge.w = o_w[ci]; ge.idx = idx[ci];
                got_q.push_back(ge);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    pe = exp_q.pop_front();
                    chk("entry_r", o_r[ci], pe.r);
                    chk("entry_k", o_k[ci], pe.k);
                    chk("entry_w", o_w[ci], pe.w);
                    chk("entry_idx", idx[ci], pe.idx);
                end
            end
            if (cyc == fin) begin
                chk("finish", finish[ci], 1);
                chk("valid_in_done", valid[ci], 0);
                for (int j = 0; j <= S_MAX; j++) chk("ptr", ptr[ci][j], exp_ptr[j]);
                chk("length", length[ci], exp_len);
                chk("overflow", ovf[ci], exp_ovf);
                chk("missing_entries", exp_q.size(), 0);
                chk_on   = 0;
                run_done = 1;
            end else if (finish[ci]) begin
                chk("early_finish", 1, 0);
            end
        end
    end

    // One complete scan. A start pulse is also placed mid-scan and in the
    // o_finish cycle; both must be ignored.
    task automatic run(input int inst, input int rn, input int sn, input int kn);
        model(inst, rn, sn, kn);
        ci    = inst;
        r_num = 3'(rn);
        s_num = 3'(sn);
        k_num = 6'(kn);
        @(negedge clk);
        start[inst] = 1'b1;
        @(posedge clk); #1;
        start[inst] = 1'b0;
        got_q.delete();
        cyc      = 0;
        run_done = 0;
        chk_on   = 1;
        // Geometry is latched; scrambling it now must not matter.
        r_num = 3'($urandom);
        s_num = 3'($urandom);
        k_num = 6'($urandom);
        for (int b = 0; b < fin + 20 && !run_done; b++) begin
            start[inst] = ((cyc == 2) && (exp_n > 4)) || (cyc == fin - 1);
            @(posedge clk); #1;
        end
        start[inst] = 1'b0;
        if (!run_done) begin
            chk("finish_timeout", 0, 1);
            chk_on = 0;
        end
        @(negedge clk);
        chk("start_at_finish_ignored", busy[inst], 0);
        @(negedge clk);
        chk("length_hold", length[inst], exp_len);
        chk("ptr_hold", ptr[inst][S_MAX], exp_ptr[S_MAX]);
    endtask

    task automatic fill(input int n, input logic [7:0] v);
        for (int a = 0; a < 1024; a++) mem[a] = (a < n) ? v : 8'd0;
    endtask

    int lr[3];
    int lk[3];
    int lw[3];
    int nfin;

    initial begin
        rst_n = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        r_num = '0; s_num = '0; k_num = '0; thresh = '0;
        fill(1024, 8'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", valid[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_finish", finish[i], 0);
            chk("rst_raddr", raddr[i], 0);
            chk("rst_length", length[i], 0);
            chk("rst_ptr", ptr[i], 0);
            chk("rst_overflow", ovf[i], 0);
        end
        rst_n = 1'b1;

        // Small hand-checked scan.
        fill(0, 8'd0);
        mem[1] = 8'd5; mem[4] = 8'hFD; mem[7] = 8'd7;
        run(0, 2, 2, 2);
        lr = '{0, 0, 1}; lk = '{1, 0, 1}; lw = '{5, 253, 7};
        chk("t1_beats", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            chk("t1_r", got_q[i].r, lr[i]);
            chk("t1_k", got_q[i].k, lk[i]);
            chk("t1_w", got_q[i].w, lw[i]);
            chk("t1_idx", got_q[i].idx, i);
        end
        chk("t1_ptr1", ptr[0][1], 1);
        chk("t1_ptr2", ptr[0][2], 3);
        chk("t1_length", length[0], 3);

        // All-zero memory at full geometry.
        fill(0, 8'd0);
        run(0, 5, 4, 32);
        chk("t2_length", length[0], 0);
        chk("t2_beats", got_q.size(), 0);

        // No columns: immediate finish, no reads.
        run(0, 2, 0, 2);
        chk("t3_length", length[0], 0);

        // Capacity 4, all ones: saturation and overflow.
        fill(8, 8'd1);
        run(1, 1, 2, 4);
        chk("t4_overflow", ovf[1], 1);
        chk("t4_length", length[1], 4);
        chk("t4_ptr1", ptr[1][1], 4);
        chk("t4_ptr4", ptr[1][4], 4);

        // Threshold pruning (or its absence in the default build).
        fill(0, 8'd0);
        mem[0] = 8'd4; mem[1] = 8'hFB; mem[2] = 8'd3; mem[3] = 8'h80;
        thresh = 7'd4;
        run(0, 1, 1, 4);
`ifdef WCSR_THRESH_EN
        chk("thr_length", length[0], 2);
        if (got_q.size() == 2) begin
            chk("thr_k0", got_q[0].k, 1);
            chk("thr_w0", got_q[0].w, 8'hFB);
            chk("thr_k1", got_q[1].k, 3);
            chk("thr_w1", got_q[1].w, 8'h80);
        end else begin
            chk("thr_beats", got_q.size(), 2);
        end
`else
        chk("thr_length", length[0], 4);
`endif

        // Randomized scans.
        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < 1024; a++)
                mem[a] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
            thresh = 7'($urandom);
            run((t % 3 == 2) ? 1 : 0, $urandom_range(0, 5), $urandom_range(0, 4),
                $urandom_range(0, 32));
        end

        // Reset mid-scan after an ignored start pulse.
        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom_range(1, 255));
        thresh = 7'd0;
        model(0, 5, 4, 32);
        ci = 0; r_num = 3'd5; s_num = 3'd4; k_num = 6'd32;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 0; run_done = 0; chk_on = 1;
        repeat (100) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (150) @(posedge clk);
        #2;
        chk_on = 0;
        chk("pre_reset_valid", valid[0], 1);
        chk("pre_reset_ptr1_set", ptr[0][1] != 11'd0, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", valid[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_ptr", ptr[0], 0);
        chk("abort_raddr", raddr[0], 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nfin = 0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (finish[0]) nfin++;
        end
        chk("no_finish_after_reset", nfin, 0);
        chk("idle_after_reset", busy[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
